// File: rtl/edge_capture.sv
// edge_capture: multi-channel edge detector and event recorder.
//
// Each channel synchronises an asynchronous input, detects rising, falling
// or both edges (EDGE_TYPE), stretches every detected edge into a pulse of
// PULSE_LEN clock cycles and latches a sticky "edge seen" flag. A shared
// saturating counter totals all detected edges across channels.
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   rst_n       asynchronous active-low reset
//   en          detection enable (stretching continues while low)
//   in          channel inputs, may be asynchronous to clk
//   clr         synchronous clear of edge_flags and edge_count
//   pulse_out   per-channel stretched edge pulse (from registered counters)
//   edge_flags  per-channel sticky edge flags, registered
//   edge_count  saturating total of detected edges, registered
//
// There is no handshake on this block: inputs are sampled every cycle and
// outputs are plain registered status, valid in every cycle out of reset.
module edge_capture #(
  parameter int    DATA_WIDTH  = 8,
  parameter string EDGE_TYPE   = "RISE",
  parameter int    SYNC_STAGES = 2,
  parameter int    PULSE_LEN   = 1,
  parameter int    COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [DATA_WIDTH-1:0]  in,
  input  logic                   clr,
  output logic [DATA_WIDTH-1:0]  pulse_out,
  output logic [DATA_WIDTH-1:0]  edge_flags,
  output logic [COUNT_WIDTH-1:0] edge_count
);

  localparam int MODE = (EDGE_TYPE == "RISE") ? 0 :
                        (EDGE_TYPE == "FALL") ? 1 :
                        (EDGE_TYPE == "BOTH") ? 2 : 3;

  localparam logic [7:0] LEN_LOAD = 8'(PULSE_LEN);

  // Elaboration-time parameter checks.
  if (MODE == 3) begin : g_bad_edge_type
    $error("edge_capture: EDGE_TYPE must be \"RISE\", \"FALL\" or \"BOTH\"");
  end
  if (SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("edge_capture: SYNC_STAGES must be 0..3");
  end
  if (PULSE_LEN < 1 || PULSE_LEN > 255) begin : g_bad_len
    $error("edge_capture: PULSE_LEN must be 1..255");
  end
  if (DATA_WIDTH < 1 || COUNT_WIDTH < $clog2(DATA_WIDTH + 1)) begin : g_bad_width
    $error("edge_capture: DATA_WIDTH >= 1 and COUNT_WIDTH >= clog2(DATA_WIDTH+1)");
  end

  // ---------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] in_s;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign in_s = in;
  end else begin : g_sync
    logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
        sync_q[0] <= in;
        for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
    end

    assign in_s = sync_q[SYNC_STAGES-1];
  end

  // ---------------------------------------------------------------------
  // prev register and priming
  // ---------------------------------------------------------------------
  // The synchroniser flops come out of reset at 0, so for SYNC_STAGES > 0 the
  // first few in_s values are reset residue, not real samples. primed is held
  // off until both in_s and prev carry post-reset samples of `in`, so a level
  // already present at reset release is never mistaken for an edge. With no
  // synchroniser this is simply the first clock edge after release.
  logic [DATA_WIDTH-1:0] prev;
  logic                  primed;
  logic [1:0]            warm_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev     <= '0;
      primed   <= 1'b0;
      warm_cnt <= '0;
    end else begin
      prev <= in_s;
      if (!primed) begin
        if (warm_cnt == 2'(SYNC_STAGES)) primed   <= 1'b1;
        else                             warm_cnt <= warm_cnt + 2'd1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Edge detection (combinational)
  // ---------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rise;
  logic [DATA_WIDTH-1:0] fall;
  logic [DATA_WIDTH-1:0] det_sel;
  logic [DATA_WIDTH-1:0] det;

  always_comb begin
    rise    = in_s & ~prev;
    fall    = ~in_s & prev;
    det_sel = '0;
    case (MODE)
      0:       det_sel = rise;
      1:       det_sel = fall;
      default: det_sel = rise | fall;
    endcase
    det = (en && primed) ? det_sel : '0;
  end

  // ---------------------------------------------------------------------
  // Pulse stretchers
  // ---------------------------------------------------------------------
  // A detection always reloads the full length, so a retrigger mid-pulse
  // extends the pulse without a gap.
  logic [7:0] stretch [DATA_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DATA_WIDTH; i++) stretch[i] <= 8'd0;
    end else begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        if (det[i])                  stretch[i] <= LEN_LOAD;
        else if (stretch[i] != 8'd0) stretch[i] <= stretch[i] - 8'd1;
      end
    end
  end

  always_comb begin
    pulse_out = '0;
    for (int i = 0; i < DATA_WIDTH; i++) pulse_out[i] = (stretch[i] != 8'd0);
  end

  // ---------------------------------------------------------------------
  // Sticky flags and saturating edge counter
  // ---------------------------------------------------------------------
  logic [COUNT_WIDTH-1:0] det_cnt;
  logic [COUNT_WIDTH:0]   count_sum;
  logic [COUNT_WIDTH-1:0] count_nxt;

  always_comb begin
    det_cnt = '0;
    for (int i = 0; i < DATA_WIDTH; i++) det_cnt = det_cnt + COUNT_WIDTH'(det[i]);
    // One extra bit catches the carry so saturation never wraps.
    count_sum = {1'b0, edge_count} + {1'b0, det_cnt};
    if (clr)                         count_nxt = det_cnt;
    else if (count_sum[COUNT_WIDTH]) count_nxt = '1;
    else                             count_nxt = count_sum[COUNT_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_flags <= '0;
      edge_count <= '0;
    end else begin
      // A detection in the same cycle as clr survives the clear.
      edge_flags <= clr ? det : (edge_flags | det);
      edge_count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_edge_capture.sv
// Testbench for edge_capture. Four instances with different configurations
// share one set of inputs; a reference model derived from the input history
// predicts every output of every instance each cycle.
module tb_edge_capture;

  localparam int DW = 8;
  localparam int NI = 4;

  // Per-instance configuration seen by the model.
  // mode: 0 = rise, 1 = fall, 2 = both
  localparam int SYNC_C [NI] = '{0, 2, 0, 3};
  localparam int LEN_C  [NI] = '{1, 3, 1, 5};
  localparam int MODE_C [NI] = '{0, 1, 2, 2};
  localparam int CMAX_C [NI] = '{65535, 65535, 15, 255};

  // ---------------------------------------------------------------------
  // Clock / reset / DUT signals
  // ---------------------------------------------------------------------
  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          en    = 1'b1;
  logic          clr   = 1'b0;
  logic [DW-1:0] din   = '0;

  logic [NI-1:0][DW-1:0] pulse;
  logic [NI-1:0][DW-1:0] flags;
  logic [15:0]           cnt0;
  logic [15:0]           cnt1;
  logic [3:0]            cnt2;
  logic [7:0]            cnt3;

  always #5 clk = ~clk;

  edge_capture #(.DATA_WIDTH(DW), .EDGE_TYPE("RISE"), .SYNC_STAGES(0),
                 .PULSE_LEN(1), .COUNT_WIDTH(16)) u_rise (
    .clk(clk), .rst_n(rst_n), .en(en), .in(din), .clr(clr),
    .pulse_out(pulse[0]), .edge_flags(flags[0]), .edge_count(cnt0));

  edge_capture #(.DATA_WIDTH(DW), .EDGE_TYPE("FALL"), .SYNC_STAGES(2),
                 .PULSE_LEN(3), .COUNT_WIDTH(16)) u_fall (
    .clk(clk), .rst_n(rst_n), .en(en), .in(din), .clr(clr),
    .pulse_out(pulse[1]), .edge_flags(flags[1]), .edge_count(cnt1));

  edge_capture #(.DATA_WIDTH(DW), .EDGE_TYPE("BOTH"), .SYNC_STAGES(0),
                 .PULSE_LEN(1), .COUNT_WIDTH(4)) u_both_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .in(din), .clr(clr),
    .pulse_out(pulse[2]), .edge_flags(flags[2]), .edge_count(cnt2));

  edge_capture #(.DATA_WIDTH(DW), .EDGE_TYPE("BOTH"), .SYNC_STAGES(3),
                 .PULSE_LEN(5), .COUNT_WIDTH(8)) u_both_sync (
    .clk(clk), .rst_n(rst_n), .en(en), .in(din), .clr(clr),
    .pulse_out(pulse[3]), .edge_flags(flags[3]), .edge_count(cnt3));

  // ---------------------------------------------------------------------
  // Scoreboard and reference model
  // ---------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  logic [31:0]   exp_q [$];       // {pulse, flags, count[15:0]} per instance
  logic [DW-1:0] hist [$];        // value of `in` at every edge since reset
  int            last_det [NI][DW];
  logic [DW-1:0] m_flags [NI];
  int            m_count [NI];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] get_count(input int i);
    case (i)
      0:       return 32'(cnt0);
      1:       return 32'(cnt1);
      2:       return 32'(cnt2);
      default: return 32'(cnt3);
    endcase
  endfunction

  task automatic model_clear();
    hist.delete();
    exp_q.delete();
    for (int i = 0; i < NI; i++) begin
      m_flags[i] = '0;
      m_count[i] = 0;
      for (int c = 0; c < DW; c++) last_det[i][c] = -1000;
    end
  endtask

  // Called just after a rising edge with the inputs that edge sampled.
  // Edge t compares the input seen SYNC edges ago against the one before it;
  // only pairs of post-reset samples are considered. A channel pulses for
  // LEN edges starting at its most recent detection.
  task automatic model_edge();
    int            t, s, n;
    logic [DW-1:0] cur, prv, edges, det, p;
    hist.push_back(din);
    t = hist.size() - 1;
    for (int i = 0; i < NI; i++) begin
      s   = SYNC_C[i];
      det = '0;
      if (t - s - 1 >= 0) begin
        cur   = hist[t-s];
        prv   = hist[t-s-1];
        edges = (MODE_C[i] == 0) ? (cur & ~prv) :
                (MODE_C[i] == 1) ? (~cur & prv) : (cur ^ prv);
        if (en) det = edges;
      end
      n = 0;
      for (int c = 0; c < DW; c++) if (det[c]) begin
        last_det[i][c] = t;
        n++;
      end
      m_flags[i] = clr ? det : (m_flags[i] | det);
      if (clr) m_count[i] = n;
      else     m_count[i] = (m_count[i] + n > CMAX_C[i]) ? CMAX_C[i] : m_count[i] + n;
      for (int c = 0; c < DW; c++) p[c] = (t - last_det[i][c]) < LEN_C[i];
      exp_q.push_back({p, m_flags[i], 16'(m_count[i])});
    end
  endtask

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  // One clock: model the rising edge, then compare on the falling edge.
  task automatic step();
    logic [31:0] e;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      e = exp_q.pop_front();
      check($sformatf("pulse%0d", i), 32'(pulse[i]), 32'(e[31:24]));
      check($sformatf("flags%0d", i), 32'(flags[i]), 32'(e[23:16]));
      check($sformatf("count%0d", i), get_count(i), 32'(e[15:0]));
    end
  endtask

  // Called on a falling edge: asserts reset between clock edges, checks that
  // every output clears without a clock, and releases on the next falling edge.
  task automatic apply_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s_rst_pulse%0d", tag, i), 32'(pulse[i]), 32'd0);
      check($sformatf("%s_rst_flags%0d", tag, i), 32'(flags[i]), 32'd0);
      check($sformatf("%s_rst_count%0d", tag, i), get_count(i), 32'd0);
    end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    model_clear();
    @(negedge clk);

    // Level high at reset release is never an edge.
    din = 8'hFF; en = 1'b1; clr = 1'b0;
    apply_reset("lvl");
    repeat (10) step();
    for (int i = 0; i < NI; i++) check($sformatf("lvl_count%0d", i), get_count(i), 32'd0);

    // 0xAA -> 0x55 with clr in the same cycle (set wins), then clr alone.
    din = 8'hAA;
    apply_reset("aa55");
    repeat (3) step();
    din = 8'h55; clr = 1'b1;
    step();
    clr = 1'b0;
    check("rise_pulse_55", 32'(pulse[0]), 32'h55);
    check("rise_flags_55", 32'(flags[0]), 32'h55);
    check("rise_count_4",  get_count(0),  32'd4);
    check("both_pulse_ff", 32'(pulse[2]), 32'hFF);
    check("both_count_8",  get_count(2),  32'd8);
    step();
    check("rise_pulse_1cyc", 32'(pulse[0]), 32'h00);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("both_flags_clr", 32'(flags[2]), 32'h00);
    check("both_count_clr", get_count(2),  32'd0);

    // FALL with 2-stage sync and length 3, then reload mid-sequence.
    din = 8'hF0;
    apply_reset("fall");
    repeat (5) step();
    din = 8'h0F;
    repeat (3) step();
    check("fall_pulse_start", 32'(pulse[1]), 32'hF0);
    din = 8'hFF;
    step();
    din = 8'h0F;
    step();
    check("fall_pulse_last", 32'(pulse[1]), 32'hF0);
    step();
    check("fall_pulse_gap", 32'(pulse[1]), 32'h00);
    step();
    check("fall_pulse_reload", 32'(pulse[1]), 32'hF0);
    repeat (3) step();
    check("fall_pulse_end", 32'(pulse[1]), 32'h00);

    // en=0: running stretch completes, no new detections, re-enable is silent.
    din = 8'h00;
    apply_reset("en");
    repeat (3) step();
    din = 8'hFF;
    repeat (4) step();
    en = 1'b0;
    din = 8'h00;
    repeat (4) step();
    check("en_stretch_runs", 32'(pulse[3]), 32'hFF);
    step();
    check("en_stretch_done", 32'(pulse[3]), 32'h00);
    din = 8'hFF;
    repeat (5) step();
    en = 1'b1;
    repeat (5) step();
    check("en_no_pulse",  32'(pulse[0]), 32'h00);
    check("en_count_hold", get_count(0), 32'd8);

    // Saturation of the 4-bit counter, then reset in the middle of a pulse.
    din = 8'h00;
    apply_reset("sat");
    repeat (2) step();
    for (int k = 0; k < 6; k++) begin
      din = ~din;
      step();
    end
    check("sat_count_15", get_count(2), 32'd15);
    repeat (3) step();
    din = ~din;
    step();
    check("sat_pulse_pre", 32'(pulse[2]), 32'hFF);
    apply_reset("mid");

    // Randomized traffic against the model.
    din = 8'($urandom);
    apply_reset("rnd");
    for (int k = 0; k < 1500; k++) begin
      case ($urandom_range(0, 3))
        0:       din = 8'($urandom);
        1:       din = din ^ (8'd1 << $urandom_range(0, 7));
        default: ;
      endcase
      en  = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 299) == 0) apply_reset("rnd_mid");
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
